// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter with locked bursts in front of one memory port.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> ACK, with ACK -> ISSUE for locked bursts.
`timescale 1ns/1ps

`ifndef ADDR_BUS
`define ADDR_BUS [31:0]
`endif
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif

module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           m0_req,
    input  logic           m0_lock,
    input  logic           m0_we,
    input  logic `ADDR_BUS m0_addr,
    input  logic [3:0]     m0_width,
    input  logic `DATA_BUS m0_wdata,
    output logic           m0_gnt,
    output logic           m0_ack,
    output logic `DATA_BUS m0_rdata,

    input  logic           m1_req,
    input  logic           m1_lock,
    input  logic           m1_we,
    input  logic `ADDR_BUS m1_addr,
    input  logic [3:0]     m1_width,
    input  logic `DATA_BUS m1_wdata,
    output logic           m1_gnt,
    output logic           m1_ack,
    output logic `DATA_BUS m1_rdata,

    output logic           mem_ce_o,
    output logic           mem_we_o,
    output logic `ADDR_BUS mem_addr_o,
    output logic [3:0]     mem_width_o,
    output logic `DATA_BUS mem_data_o,
    input  logic `DATA_BUS mem_data_i
);

    localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_t;

    state_t state_q, state_d;

    logic            owner_q;     // master owning the current transaction
    logic            last_q;      // last_owner for round-robin
    logic [CntW-1:0] burst_q, burst_d;
    logic            hold_we_q;
    logic `ADDR_BUS  hold_addr_q;
    logic [3:0]      hold_width_q;
    logic `DATA_BUS  hold_wdata_q;
    logic `DATA_BUS  rdata0_q, rdata1_q;

    logic load;                   // capture a command into the holding registers
    logic load_sel;               // which master's command to capture
    logic win;
    logic own_req, own_lock, other_req;
    logic cont;

    // Both requesting: the master that did not own the last grant wins.
    assign win       = (m0_req && m1_req) ? !last_q : m1_req;
    assign own_req   = owner_q ? m1_req  : m0_req;
    assign own_lock  = owner_q ? m1_lock : m0_lock;
    assign other_req = owner_q ? m0_req  : m1_req;
    // Lock may continue below the burst limit, or at the limit when nobody else is waiting.
    assign cont      = own_lock && own_req && ((burst_q < BurstMax) || !other_req);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, command capture and burst counting decisions.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_sel = owner_q;
        burst_d  = burst_q;
        case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    state_d  = StIssue;
                    load     = 1'b1;
                    load_sel = win;
                    burst_d  = '0;
                end
            end
            StIssue: state_d = StWait;
            StWait:  state_d = StAck;
            StAck: begin
                if (cont) begin
                    state_d  = StIssue;
                    load     = 1'b1;
                    load_sel = owner_q;
                    if (burst_q < BurstMax) begin
                        burst_d = burst_q + 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                    burst_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding registers, ownership, burst counter and per-master read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            burst_q      <= '0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_width_q <= '0;
            hold_wdata_q <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            burst_q <= burst_d;
            if (load) begin
                owner_q      <= load_sel;
                last_q       <= load_sel;
                hold_we_q    <= load_sel ? m1_we    : m0_we;
                hold_addr_q  <= load_sel ? m1_addr  : m0_addr;
                hold_width_q <= load_sel ? m1_width : m0_width;
                hold_wdata_q <= load_sel ? m1_wdata : m0_wdata;
            end
            if (state_q == StWait && !hold_we_q) begin
                if (owner_q) begin
                    rdata1_q <= mem_data_i;
                end else begin
                    rdata0_q <= mem_data_i;
                end
            end
        end
    end

    // Outputs decoded from state; memory bus is zero outside ISSUE.
    always_comb begin
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        m0_ack      = 1'b0;
        m1_ack      = 1'b0;
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_width_o = '0;
        mem_data_o  = '0;
        case (state_q)
            StIssue: begin
                m0_gnt      = !owner_q;
                m1_gnt      = owner_q;
                mem_ce_o    = 1'b1;
                mem_we_o    = hold_we_q;
                mem_addr_o  = hold_addr_q;
                mem_width_o = hold_width_q;
                mem_data_o  = hold_wdata_q;
            end
            StAck: begin
                m0_ack = !owner_q;
                m1_ack = owner_q;
            end
            default: ;
        endcase
    end

    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized masters, checked cycle by cycle against a
// transaction-timeline model of the arbiter and an independent memory image.
`timescale 1ns/1ps

`ifndef ADDR_BUS
`define ADDR_BUS [31:0]
`endif
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif

module tb_mem_arbiter;

    localparam int MaxBurst = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req   [2];
    logic        lock  [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [3:0]  width [2];
    logic [31:0] wdata [2];

    logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_ce_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic [3:0]  mem_width_o;

    mem_arbiter #(.MAX_BURST(MaxBurst)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (req[0]),
        .m0_lock    (lock[0]),
        .m0_we      (we[0]),
        .m0_addr    (addr[0]),
        .m0_width   (width[0]),
        .m0_wdata   (wdata[0]),
        .m0_gnt     (m0_gnt),
        .m0_ack     (m0_ack),
        .m0_rdata   (m0_rdata),
        .m1_req     (req[1]),
        .m1_lock    (lock[1]),
        .m1_we      (we[1]),
        .m1_addr    (addr[1]),
        .m1_width   (width[1]),
        .m1_wdata   (wdata[1]),
        .m1_gnt     (m1_gnt),
        .m1_ack     (m1_ack),
        .m1_rdata   (m1_rdata),
        .mem_ce_o   (mem_ce_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_width_o(mem_width_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, 8'h3C};
    endfunction

    // Synchronous SRAM seen by the arbiter: command at the ISSUE edge, read data during WAIT.
    logic [31:0] sram [256];
    bit          written [256];
    logic [31:0] sram_q;
    always @(posedge clk) begin
        if (mem_ce_o) begin
            if (mem_we_o) begin
                sram[mem_addr_o[7:0]]    <= mem_data_o;
                written[mem_addr_o[7:0]] <= 1'b1;
            end else begin
                sram_q <= written[mem_addr_o[7:0]] ? sram[mem_addr_o[7:0]]
                                                   : init_val(mem_addr_o[7:0]);
            end
        end
    end
    assign mem_data_i = sram_q;

    // Reference model: a transaction is a timeline of issue at t_iss, ack at t_iss+2.
    int          cyc;
    bit          act;
    int          t_iss;
    bit          own;
    bit          last;
    int          burst;
    bit          h_we;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_width;
    logic [31:0] m_rd  [2];
    logic [31:0] m_mem [256];

    int n_tests;
    int n_fail;

    int g_who [$];
    int g_cyc [$];
    int exp_who [7] = '{0, 0, 0, 0, 1, 0, 0};
    int exp_gap [6] = '{3, 3, 3, 4, 4, 3};
    int n0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_start(input bit w);
        own     = w;
        last    = w;
        h_we    = we[w];
        h_addr  = addr[w];
        h_width = width[w];
        h_wdata = wdata[w];
        act     = 1'b1;
        t_iss   = cyc + 1;
    endtask

    task automatic model_edge();
        // The memory takes the write at the issue edge even if reset lands on that edge.
        if (act && cyc == t_iss && h_we) m_mem[h_addr[7:0]] = h_wdata;
        if (rst) begin
            act     = 1'b0;
            last    = 1'b1;
            burst   = 0;
            m_rd[0] = '0;
            m_rd[1] = '0;
        end else if (!act) begin
            if (req[0] && req[1]) model_start(!last);
            else if (req[0])      model_start(1'b0);
            else if (req[1])      model_start(1'b1);
        end else if (cyc == t_iss + 1) begin
            if (!h_we) m_rd[own] = m_mem[h_addr[7:0]];
        end else if (cyc == t_iss + 2) begin
            if (lock[own] && req[own] && (burst < MaxBurst - 1 || !req[!own])) begin
                if (burst < MaxBurst - 1) burst++;
                model_start(own);
            end else begin
                act   = 1'b0;
                burst = 0;
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        logic iss, ak;
        iss = act && (cyc == t_iss);
        ak  = act && (cyc == t_iss + 2);
        check("m0_gnt",    32'(m0_gnt),      32'(iss && !own));
        check("m1_gnt",    32'(m1_gnt),      32'(iss && own));
        check("m0_ack",    32'(m0_ack),      32'(ak && !own));
        check("m1_ack",    32'(m1_ack),      32'(ak && own));
        check("m0_rdata",  m0_rdata,         m_rd[0]);
        check("m1_rdata",  m1_rdata,         m_rd[1]);
        check("mem_ce",    32'(mem_ce_o),    32'(iss));
        check("mem_we",    32'(mem_we_o),    32'(iss && h_we));
        check("mem_addr",  mem_addr_o,       iss ? h_addr : 32'd0);
        check("mem_width", 32'(mem_width_o), iss ? 32'(h_width) : 32'd0);
        check("mem_data",  mem_data_o,       iss ? h_wdata : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    // Single unlocked transaction with explicit latency checks.
    task automatic txn(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] wd, input string tag);
        req[m] = 1'b1; lock[m] = 1'b0; we[m] = w; addr[m] = a; wdata[m] = d; width[m] = wd;
        step();
        check({tag, "_gnt"}, 32'(m != 0 ? m1_gnt : m0_gnt), 32'd1);
        check({tag, "_we"},  32'(mem_we_o), 32'(w));
        req[m] = 1'b0;
        step();
        check({tag, "_ce_low"}, 32'(mem_ce_o), 32'd0);
        step();
        check({tag, "_ack"}, 32'(m != 0 ? m1_ack : m0_ack), 32'd1);
        step();
    endtask

    task automatic rand_master(input int i);
        bit g;
        g = act && (cyc == t_iss) && (own == 1'(i));
        if (req[i] && !g) return;  // command held until its grant
        if ($urandom_range(0, 2) != 0) begin
            req[i]   = 1'b1;
            lock[i]  = 1'($urandom_range(0, 1));
            we[i]    = 1'($urandom_range(0, 1));
            addr[i]  = 32'($urandom_range(0, 63));
            width[i] = 4'($urandom_range(0, 15));
            wdata[i] = $urandom;
        end else begin
            req[i]  = 1'b0;
            lock[i] = 1'b0;
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        cyc = 0; act = 1'b0; t_iss = -10; own = 1'b0; last = 1'b1; burst = 0;
        h_we = 1'b0; h_addr = '0; h_wdata = '0; h_width = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        for (int a = 0; a < 256; a++) m_mem[a] = init_val(8'(a));
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; lock[i] = 1'b0; we[i] = 1'b0;
            addr[i] = '0; width[i] = '0; wdata[i] = '0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        check("rst_mem_ce",   32'(mem_ce_o), 32'd0);

        // Single read of the preloaded word.
        txn(0, 1'b0, 32'h10, 32'd0, 4'hF, "rd10");
        check("rd10_data", m0_rdata, 32'hDEADBEEF);

        // Contention right after reset: m0 first, m1 granted after m0's ack and an IDLE.
        rst = 1'b1; step(); rst = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h30; lock[0] = 1'b0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h31; lock[1] = 1'b0;
        step();
        check("cont_m0_gnt", 32'(m0_gnt), 32'd1);
        check("cont_m1_wait", 32'(m1_gnt), 32'd0);
        req[0] = 1'b0;
        step();
        step();
        check("cont_m0_ack", 32'(m0_ack), 32'd1);
        step();
        check("cont_idle_gnt", 32'(m1_gnt), 32'd0);
        step();
        check("cont_m1_gnt", 32'(m1_gnt), 32'd1);
        req[1] = 1'b0;
        step();
        step();
        check("cont_m1_ack", 32'(m1_ack), 32'd1);
        check("cont_m0_data", m0_rdata, init_val(8'h30));
        check("cont_m1_data", m1_rdata, init_val(8'h31));
        step();

        // Write then read by m1; the write leaves m1_rdata alone.
        txn(1, 1'b0, 32'h21, 32'd0, 4'hF, "rd21");
        check("rd21_data", m1_rdata, init_val(8'h21));
        txn(1, 1'b1, 32'h20, 32'h12345678, 4'b1111, "wr20");
        check("wr20_rdata_kept", m1_rdata, init_val(8'h21));
        txn(1, 1'b0, 32'h20, 32'd0, 4'hF, "rd20");
        check("rd20_data", m1_rdata, 32'h12345678);

        // Locked burst of six m0 reads against a waiting m1.
        rst = 1'b1; step(); rst = 1'b0;
        req[0] = 1'b1; lock[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40;
        req[1] = 1'b1; lock[1] = 1'b0; we[1] = 1'b0; addr[1] = 32'h50;
        n0 = 0;
        for (int k = 0; k < 60 && (req[0] || req[1]); k++) begin
            step();
            if (m0_gnt) begin
                g_who.push_back(0); g_cyc.push_back(cyc); n0++;
                if (n0 < 6) addr[0] = 32'h40 + 32'(n0);
                else begin req[0] = 1'b0; lock[0] = 1'b0; end
            end
            if (m1_gnt) begin
                g_who.push_back(1); g_cyc.push_back(cyc); req[1] = 1'b0;
            end
        end
        check("burst_done", 32'(req[0] || req[1]), 32'd0);
        check("burst_grants", 32'(g_who.size()), 32'd7);
        for (int i = 0; i < 7 && i < g_who.size(); i++) begin
            check($sformatf("burst_who%0d", i), 32'(g_who[i]), 32'(exp_who[i]));
            if (i > 0) check($sformatf("burst_gap%0d", i), 32'(g_cyc[i] - g_cyc[i-1]),
                             32'(exp_gap[i-1]));
        end
        step(); step(); step();
        check("burst_m0_data", m0_rdata, init_val(8'h45));

        // Reset during the WAIT of an m1 read abandons it; m0 then wins contention.
        rst = 1'b1; step(); rst = 1'b0;
        req[1] = 1'b1; lock[1] = 1'b0; we[1] = 1'b0; addr[1] = 32'h22;
        step();
        check("rstmid_m1_gnt", 32'(m1_gnt), 32'd1);
        req[1] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_no_ack", 32'(m1_ack), 32'd0);
        check("rstmid_ce", 32'(mem_ce_o), 32'd0);
        check("rstmid_rdata", m1_rdata, 32'd0);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h23; lock[0] = 1'b0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h24;
        step();
        check("rstmid_m0_wins", 32'(m0_gnt), 32'd1);
        check("rstmid_m1_waits", 32'(m1_gnt), 32'd0);
        req[0] = 1'b0;
        step(); step(); step(); step();
        check("rstmid_m1_later", 32'(m1_gnt), 32'd1);
        req[1] = 1'b0;
        step(); step(); step();

        // Randomized masters with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            rand_master(0);
            rand_master(1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
